bp_me_cache_dma_to_mem: RTL and testbench
=========================================

Name: bp_me_cache_dma_to_mem

Overview:
Per-bank DMA adapter placed directly downstream of one L2 cache bank's DMA interface. It converts block-granular DMA packets (fill or evict) plus their data streams into single-beat memory commands on a simple in-order memory port. Read fills are flow-controlled by a credit counter feeding a local return buffer, so memory responses never need backpressure. One instance is used per L2 bank.

Parameters:
addr_width_p, 28, DMA/memory byte-address width (daddr width)
fill_width_p, 64, data beat width in bits; must be a multiple of 8
block_size_in_fill_p, 8, beats per cache block; power of 2
els_p, 4, read-return buffer depth and initial credit count; power of 2, at least 2

Ports:
clk_i  in  1  clock
reset_n_i  in  1  one clock; reset is asynchronous and active-low
dma_pkt_i  in  addr_width_p+1  {write_not_read (MSB), addr}
dma_pkt_v_i  in  1  packet valid
dma_pkt_ready_and_o  out  1  packet ready
dma_data_o  out  fill_width_p  fill data to cache
dma_data_v_o  out  1  fill data valid
dma_data_ready_and_i  in  1  cache accepts fill beat
dma_data_i  in  fill_width_p  evict data from cache
dma_data_v_i  in  1  evict beat valid
dma_data_ready_and_o  out  1  evict beat accepted
mem_cmd_v_o  out  1  memory command valid
mem_cmd_w_o  out  1  1 = write, 0 = read
mem_cmd_addr_o  out  addr_width_p  beat byte address
mem_cmd_data_o  out  fill_width_p  write data
mem_cmd_ready_and_i  in  1  memory accepts command
mem_resp_data_i  in  fill_width_p  read data; returned in command order
mem_resp_v_i  in  1  read data valid; no ready

Behaviour:
- Handshake: a transfer occurs on a cycle where valid and ready are both high. No output valid depends combinationally on its own ready.
- Derived constants:
  - fill_bytes = fill_width_p/8.
  - offset_bits = log2(block_size_in_fill_p*fill_bytes).
- FSM states: IDLE, READ, WRITE.
- IDLE:
  - dma_pkt_ready_and_o = 1.
  - On packet accept, latch base = addr with the low offset_bits cleared, and clear beat counter cnt.
  - Go to WRITE if write_not_read = 1, otherwise READ.
- READ:
  - mem_cmd_v_o = (credits != 0), mem_cmd_w_o = 0.
  - mem_cmd_addr_o = base + cnt*fill_bytes.
  - On each command accept, cnt increments and credits decrement.
  - After the accept with cnt = block_size_in_fill_p-1, go to IDLE. Responses may still be in flight; this is legal because the memory returns data in order.
- WRITE:
  - mem_cmd_v_o = dma_data_v_i, mem_cmd_w_o = 1, mem_cmd_data_o = dma_data_i.
  - mem_cmd_addr_o = base + cnt*fill_bytes.
  - dma_data_ready_and_o = mem_cmd_ready_and_i. It is 0 in every other state.
  - After the last beat is accepted, go to IDLE.
- Address arithmetic: no carry out of the block, because cnt < block_size_in_fill_p.
- cnt width: log2(block_size_in_fill_p).
- Return buffer:
  - els_p-deep FIFO written by mem_resp_v_i and drained to dma_data_o/dma_data_v_o.
  - Zero-cycle bypass is not required: a response appears on dma_data_o no earlier than the next cycle.
- Credits:
  - Counter range 0..els_p; resets to els_p.
  - Decrements on a read command accept; increments on a dma_data_o handshake.
  - Both in the same cycle: value unchanged.
  - Credits never exceed els_p, and mem_resp_v_i never arrives with the FIFO full.
  - Assertions flag either violation.
- Reset (asynchronous, active-low):
  - All outputs go to 0 immediately, including dma_pkt_ready_and_o.
  - State returns to IDLE, credits = els_p, FIFO is emptied.
  - Mid-operation reset discards the partial block. The memory model must be reset in the same domain; stale responses are illegal.
  - On the first cycle after deassertion, dma_pkt_ready_and_o = 1.
- Latency: a packet accepted in cycle t gives its first mem_cmd_v_o in cycle t+1.

Test Plan:
1. Read pkt {0, 0x0010048}, memory always ready, returns data 0xA0..0xA7 one cycle after each command -> 8 reads to addrs 0x0010040, 0x0010048 … 0x0010078; dma_data_o delivers A0..A7 in order; credits end at 4.
2. Read pkt with dma_data_ready_and_i = 0 -> exactly 4 read commands issued, then mem_cmd_v_o stays 0. Raise ready -> remaining 4 commands issue; all 8 beats delivered in order.
3. Write pkt {1, 0x0000200} with beats D0..D7; mem_cmd_ready_and_i toggles 1,0,1,0 and dma_data_v_i has bubbles -> 8 writes to 0x200..0x238 with data D0..D7; no duplicates or drops; back in IDLE.
4. Read pkt, then a write pkt offered on the cycle after the 8th read accept -> write accepted in IDLE the next cycle. Write commands interleave after all reads issue, while the fill data still drains in order.
5. Assert reset_n_i low after 3 read beats -> all outputs 0 in the same cycle. After release: dma_pkt_ready_and_o = 1, credits = 4, FIFO empty.
6. With credits = 1, issue a read command and a fill handshake in the same cycle -> credits remain 1; the next read issues in the following cycle.

Source files
------------

// File: rtl/bp_me_cache_dma_to_mem.sv
// Per-bank DMA adapter between one L2 bank's DMA port and a simple in-order memory port.
// A block-granular DMA packet (fill or evict) is expanded into block_size_in_fill_p single-beat
// memory commands. Read data returns through a small buffer whose space is reserved by a credit
// counter, so the memory response channel never needs backpressure.
//
// Ports:
//   clk_i, reset_n_i            clock, asynchronous active-low reset
//   dma_pkt_i/_v_i/_ready_and_o {write_not_read, addr} packet from the cache
//   dma_data_o/_v_o/_ready_and_i fill beats returned to the cache
//   dma_data_i/_v_i/_ready_and_o evict beats from the cache
//   mem_cmd_*                   single-beat memory command (w=1 write, w=0 read)
//   mem_resp_data_i/_v_i        read data, in command order, no ready
module bp_me_cache_dma_to_mem #(
    parameter int unsigned addr_width_p         = 28,
    parameter int unsigned fill_width_p         = 64,
    parameter int unsigned block_size_in_fill_p = 8,
    parameter int unsigned els_p                = 4
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,

    input  logic [addr_width_p:0]   dma_pkt_i,
    input  logic                    dma_pkt_v_i,
    output logic                    dma_pkt_ready_and_o,

    output logic [fill_width_p-1:0] dma_data_o,
    output logic                    dma_data_v_o,
    input  logic                    dma_data_ready_and_i,

    input  logic [fill_width_p-1:0] dma_data_i,
    input  logic                    dma_data_v_i,
    output logic                    dma_data_ready_and_o,

    output logic                    mem_cmd_v_o,
    output logic                    mem_cmd_w_o,
    output logic [addr_width_p-1:0] mem_cmd_addr_o,
    output logic [fill_width_p-1:0] mem_cmd_data_o,
    input  logic                    mem_cmd_ready_and_i,

    input  logic [fill_width_p-1:0] mem_resp_data_i,
    input  logic                    mem_resp_v_i
);

    localparam int unsigned FillBytes    = fill_width_p / 8;
    localparam int unsigned FillByteBits = $clog2(FillBytes);
    localparam int unsigned OffsetBits   = $clog2(block_size_in_fill_p * FillBytes);
    localparam int unsigned CntW  = (block_size_in_fill_p > 1) ? $clog2(block_size_in_fill_p) : 1;
    localparam int unsigned PtrW  = $clog2(els_p);
    localparam int unsigned CredW = $clog2(els_p + 1);

    localparam logic [CntW-1:0]         LastCnt  = CntW'(block_size_in_fill_p - 1);
    localparam logic [CredW-1:0]        CredMax  = CredW'(els_p);
    localparam logic [addr_width_p-1:0] BaseMask = {addr_width_p{1'b1}} << OffsetBits;

    typedef enum logic [1:0] {StIdle, StRead, StWrite} state_e;

    state_e                  state_q, state_d;
    logic [addr_width_p-1:0] base_q, base_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [CredW-1:0]        credits_q, credits_d;

    logic                    pkt_write;
    logic [addr_width_p-1:0] pkt_addr;
    logic [addr_width_p-1:0] beat_offset;

    logic                    pkt_ready;
    logic                    cmd_v;
    logic                    cmd_w;
    logic [fill_width_p-1:0] cmd_data;
    logic                    evict_ready;
    logic                    read_acc;

    // Return buffer: pointers carry one extra wrap bit to tell full from empty.
    logic [fill_width_p-1:0] fifo_mem [els_p];
    logic [PtrW:0]           wptr_q, rptr_q;
    logic                    fifo_empty, fifo_full;
    logic                    fifo_push, fifo_pop;

    assign pkt_write   = dma_pkt_i[addr_width_p];
    assign pkt_addr    = dma_pkt_i[addr_width_p-1:0];
    // cnt stays below block_size_in_fill_p, so the offset never carries out of the block.
    assign beat_offset = addr_width_p'(cnt_q) << FillByteBits;

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        cnt_d       = cnt_q;
        pkt_ready   = 1'b0;
        cmd_v       = 1'b0;
        cmd_w       = 1'b0;
        cmd_data    = '0;
        evict_ready = 1'b0;
        read_acc    = 1'b0;
        unique case (state_q)
            StIdle: begin
                pkt_ready = 1'b1;
                if (dma_pkt_v_i) begin
                    base_d  = pkt_addr & BaseMask;
                    cnt_d   = '0;
                    state_d = pkt_write ? StWrite : StRead;
                end
            end
            StRead: begin
                // A read is only issued once buffer space for its response is reserved.
                cmd_v    = (credits_q != '0);
                read_acc = cmd_v && mem_cmd_ready_and_i;
                if (read_acc) begin
                    cnt_d = cnt_q + CntW'(1);
                    // Responses may still be in flight; memory returns them in order.
                    if (cnt_q == LastCnt) state_d = StIdle;
                end
            end
            StWrite: begin
                cmd_v       = dma_data_v_i;
                cmd_w       = 1'b1;
                cmd_data    = dma_data_i;
                evict_ready = mem_cmd_ready_and_i;
                if (dma_data_v_i && mem_cmd_ready_and_i) begin
                    cnt_d = cnt_q + CntW'(1);
                    if (cnt_q == LastCnt) state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign fifo_empty = (wptr_q == rptr_q);
    assign fifo_full  = (wptr_q[PtrW] != rptr_q[PtrW]) &&
                        (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);
    assign fifo_push  = mem_resp_v_i && !fifo_full;
    assign fifo_pop   = !fifo_empty && dma_data_ready_and_i;

    always_comb begin
        credits_d = credits_q;
        if (read_acc && !fifo_pop) begin
            credits_d = credits_q - CredW'(1);
        end else if (!read_acc && fifo_pop) begin
            credits_d = credits_q + CredW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= StIdle;
            base_q    <= '0;
            cnt_q     <= '0;
            credits_q <= CredMax;
            wptr_q    <= '0;
            rptr_q    <= '0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            cnt_q     <= cnt_d;
            credits_q <= credits_d;
            if (fifo_push) wptr_q <= wptr_q + (PtrW+1)'(1);
            if (fifo_pop)  rptr_q <= rptr_q + (PtrW+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (fifo_push) fifo_mem[wptr_q[PtrW-1:0]] <= mem_resp_data_i;
    end

    // Every output is forced low while reset is asserted, without waiting for a clock.
    assign dma_pkt_ready_and_o  = reset_n_i & pkt_ready;
    assign mem_cmd_v_o          = reset_n_i & cmd_v;
    assign mem_cmd_w_o          = reset_n_i & cmd_w;
    assign mem_cmd_addr_o       = reset_n_i ? (base_q + beat_offset) : '0;
    assign mem_cmd_data_o       = reset_n_i ? cmd_data : '0;
    assign dma_data_ready_and_o = reset_n_i & evict_ready;
    assign dma_data_v_o         = reset_n_i & !fifo_empty;
    assign dma_data_o           = reset_n_i ? fifo_mem[rptr_q[PtrW-1:0]] : '0;

    credits_le_max: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        credits_q <= CredMax);
    no_resp_when_full: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(mem_resp_v_i && fifo_full));

endmodule

// File: tb/tb_bp_me_cache_dma_to_mem.sv
module tb_bp_me_cache_dma_to_mem;

    localparam int AW  = 28;
    localparam int FW  = 64;
    localparam int BLK = 8;
    localparam int ELS = 4;
    localparam int BlkBytes = BLK * FW / 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [AW:0]   dma_pkt;
    logic          dma_pkt_v;
    logic          dma_pkt_ready;
    logic [FW-1:0] dma_data_out;
    logic          dma_data_v_out;
    logic          dma_data_ready_in;
    logic [FW-1:0] dma_data_in;
    logic          dma_data_v_in;
    logic          dma_data_ready_out;
    logic          mem_cmd_v;
    logic          mem_cmd_w;
    logic [AW-1:0] mem_cmd_addr;
    logic [FW-1:0] mem_cmd_data;
    logic          mem_cmd_ready;
    logic [FW-1:0] mem_resp_data;
    logic          mem_resp_v;

    always #5 clk = ~clk;

    bp_me_cache_dma_to_mem #(
        .addr_width_p         (AW),
        .fill_width_p         (FW),
        .block_size_in_fill_p (BLK),
        .els_p                (ELS)
    ) dut (
        .clk_i                (clk),
        .reset_n_i            (reset_n),
        .dma_pkt_i            (dma_pkt),
        .dma_pkt_v_i          (dma_pkt_v),
        .dma_pkt_ready_and_o  (dma_pkt_ready),
        .dma_data_o           (dma_data_out),
        .dma_data_v_o         (dma_data_v_out),
        .dma_data_ready_and_i (dma_data_ready_in),
        .dma_data_i           (dma_data_in),
        .dma_data_v_i         (dma_data_v_in),
        .dma_data_ready_and_o (dma_data_ready_out),
        .mem_cmd_v_o          (mem_cmd_v),
        .mem_cmd_w_o          (mem_cmd_w),
        .mem_cmd_addr_o       (mem_cmd_addr),
        .mem_cmd_data_o       (mem_cmd_data),
        .mem_cmd_ready_and_i  (mem_cmd_ready),
        .mem_resp_data_i      (mem_resp_data),
        .mem_resp_v_i         (mem_resp_v)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int mem_mode  = 0;  // 0 hold, 1 toggle, 2 random
    int fill_mode = 0;  // 0 hold, 2 random
    bit evict_bubbles = 1'b0;
    int pkt_acc_cyc   = -1;
    int first_cmd_cyc = -1;

    logic [FW-1:0] src_q[$];
    logic [AW-1:0] log_addr[$];
    logic          log_w[$];
    logic [FW-1:0] log_data[$];
    logic [FW-1:0] fill_log[$];
    logic [FW-1:0] mem_model [logic [AW-1:0]];

    // Memory contents: written words are remembered, untouched words derive from the address.
    function automatic logic [FW-1:0] mem_read(input logic [AW-1:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return {36'h0BEEF0000, a};
    endfunction

    function automatic logic [AW-1:0] beat_addr(input logic [AW-1:0] a, input int i);
        return (a & ~AW'(BlkBytes - 1)) + AW'(i * (FW / 8));
    endfunction

    task automatic clear_logs();
        log_addr.delete();
        log_w.delete();
        log_data.delete();
        fill_log.delete();
    endtask

    // One clock: observe handshakes just before the rising edge, then play memory and cache
    // for the next cycle right after the falling edge.
    task automatic tick();
        bit            pkt_acc;
        bit            ev_acc;
        bit            rd_acc;
        logic [FW-1:0] rd_data;
        #1;
        pkt_acc = dma_pkt_v && dma_pkt_ready;
        if (mem_cmd_v && first_cmd_cyc < 0) first_cmd_cyc = cyc;
        if (pkt_acc) begin
            pkt_acc_cyc   = cyc;
            first_cmd_cyc = -1;
        end
        rd_acc  = 1'b0;
        rd_data = '0;
        if (mem_cmd_v && mem_cmd_ready) begin
            log_addr.push_back(mem_cmd_addr);
            log_w.push_back(mem_cmd_w);
            log_data.push_back(mem_cmd_data);
            if (mem_cmd_w) begin
                mem_model[mem_cmd_addr] = mem_cmd_data;
            end else begin
                rd_acc  = 1'b1;
                rd_data = mem_read(mem_cmd_addr);
            end
        end
        if (dma_data_v_out && dma_data_ready_in) fill_log.push_back(dma_data_out);
        ev_acc = dma_data_v_in && dma_data_ready_out;
        @(negedge clk);
        cyc++;
        if (pkt_acc) dma_pkt_v = 1'b0;
        if (ev_acc && src_q.size() > 0) src_q.delete(0);
        mem_resp_v    = rd_acc;
        mem_resp_data = rd_data;
        if (mem_mode == 1) mem_cmd_ready = ~mem_cmd_ready;
        else if (mem_mode == 2) mem_cmd_ready = 1'($urandom_range(0, 1));
        if (fill_mode == 2) dma_data_ready_in = 1'($urandom_range(0, 1));
        if (src_q.size() > 0) begin
            dma_data_v_in = evict_bubbles ? 1'($urandom_range(0, 1)) : 1'b1;
            dma_data_in   = src_q[0];
        end else begin
            dma_data_v_in = 1'b0;
            dma_data_in   = '0;
        end
    endtask

    task automatic test_reset();
        reset_n           = 1'b0;
        dma_pkt           = '0;
        dma_pkt_v         = 1'b0;
        dma_data_ready_in = 1'b0;
        dma_data_in       = '0;
        dma_data_v_in     = 1'b0;
        mem_cmd_ready     = 1'b0;
        mem_resp_data     = '0;
        mem_resp_v        = 1'b0;
        #1;
        n_checks++;
        if (dma_pkt_ready !== 1'b0 || mem_cmd_v !== 1'b0 || dma_data_v_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ready=%b cmd_v=%b fill_v=%b required all 0",
                     dma_pkt_ready, mem_cmd_v, dma_data_v_out);
        end
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        n_checks++;
        if (dma_pkt_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b required 1", dma_pkt_ready);
        end
        n_checks++;
        if (dut.credits_q !== 3'(ELS)) begin
            n_fail++;
            $display("FAIL reset_credits: got %0d required %0d", dut.credits_q, ELS);
        end
    endtask

    task automatic test_read_basic();
        logic [AW-1:0] a;
        a = 28'h0010048;
        clear_logs();
        for (int i = 0; i < BLK; i++) mem_model[beat_addr(a, i)] = 64'hA0 + 64'(i);
        mem_mode = 0; mem_cmd_ready = 1'b1;
        fill_mode = 0; dma_data_ready_in = 1'b1;
        dma_pkt = {1'b0, a}; dma_pkt_v = 1'b1;
        for (int i = 0; i < 200 && fill_log.size() < BLK; i++) tick();
        for (int i = 0; i < 4; i++) tick();
        n_checks++;
        if (log_addr.size() != BLK || fill_log.size() != BLK) begin
            n_fail++;
            $display("FAIL rd_counts: got cmds=%0d fills=%0d required %0d each",
                     log_addr.size(), fill_log.size(), BLK);
        end
        for (int i = 0; i < BLK && i < log_addr.size(); i++) begin
            n_checks++;
            if (log_addr[i] !== beat_addr(a, i) || log_w[i] !== 1'b0) begin
                n_fail++;
                $display("FAIL rd_cmd[%0d]: got addr=%h w=%b required addr=%h w=0",
                         i, log_addr[i], log_w[i], beat_addr(a, i));
            end
        end
        for (int i = 0; i < BLK && i < fill_log.size(); i++) begin
            n_checks++;
            if (fill_log[i] !== 64'hA0 + 64'(i)) begin
                n_fail++;
                $display("FAIL rd_fill[%0d]: got %h required %h", i, fill_log[i], 64'hA0 + 64'(i));
            end
        end
        n_checks++;
        if (first_cmd_cyc != pkt_acc_cyc + 1) begin
            n_fail++;
            $display("FAIL rd_latency: got first cmd cycle %0d required %0d",
                     first_cmd_cyc, pkt_acc_cyc + 1);
        end
        n_checks++;
        if (dut.credits_q !== 3'(ELS)) begin
            n_fail++;
            $display("FAIL rd_credits_end: got %0d required %0d", dut.credits_q, ELS);
        end
    endtask

    task automatic test_fill_backpressure();
        logic [AW-1:0] a;
        logic [FW-1:0] exp_fill[$];
        a = AW'($urandom);
        clear_logs();
        for (int i = 0; i < BLK; i++) exp_fill.push_back(mem_read(beat_addr(a, i)));
        mem_mode = 0; mem_cmd_ready = 1'b1;
        fill_mode = 0; dma_data_ready_in = 1'b0;
        dma_pkt = {1'b0, a}; dma_pkt_v = 1'b1;
        for (int i = 0; i < 30; i++) tick();
        #1;
        n_checks++;
        if (log_addr.size() != ELS || mem_cmd_v !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_stall: got cmds=%0d cmd_v=%b required cmds=%0d cmd_v=0",
                     log_addr.size(), mem_cmd_v, ELS);
        end
        n_checks++;
        if (dma_data_v_out !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_fill_valid: got %b required 1", dma_data_v_out);
        end
        dma_data_ready_in = 1'b1;
        for (int i = 0; i < 200 && fill_log.size() < BLK; i++) tick();
        n_checks++;
        if (log_addr.size() != BLK || fill_log.size() != BLK) begin
            n_fail++;
            $display("FAIL bp_counts: got cmds=%0d fills=%0d required %0d each",
                     log_addr.size(), fill_log.size(), BLK);
        end
        for (int i = 0; i < BLK && i < log_addr.size(); i++) begin
            n_checks++;
            if (log_addr[i] !== beat_addr(a, i)) begin
                n_fail++;
                $display("FAIL bp_addr[%0d]: got %h required %h", i, log_addr[i], beat_addr(a, i));
            end
        end
        for (int i = 0; i < BLK && i < fill_log.size(); i++) begin
            n_checks++;
            if (fill_log[i] !== exp_fill[i]) begin
                n_fail++;
                $display("FAIL bp_fill[%0d]: got %h required %h", i, fill_log[i], exp_fill[i]);
            end
        end
    endtask

    task automatic test_write();
        logic [AW-1:0] a;
        a = 28'h0000200;
        clear_logs();
        for (int i = 0; i < BLK; i++) src_q.push_back(64'hD0 + 64'(i));
        evict_bubbles = 1'b1;
        dma_data_v_in = 1'b1; dma_data_in = src_q[0];
        mem_mode = 1; mem_cmd_ready = 1'b1;
        dma_pkt = {1'b1, a}; dma_pkt_v = 1'b1;
        for (int i = 0; i < 300 && log_addr.size() < BLK; i++) tick();
        for (int i = 0; i < 6; i++) tick();
        n_checks++;
        if (log_addr.size() != BLK || src_q.size() != 0) begin
            n_fail++;
            $display("FAIL wr_counts: got cmds=%0d beats_left=%0d required %0d and 0",
                     log_addr.size(), src_q.size(), BLK);
        end
        for (int i = 0; i < BLK && i < log_addr.size(); i++) begin
            n_checks++;
            if (log_addr[i] !== beat_addr(a, i) || log_w[i] !== 1'b1 ||
                log_data[i] !== 64'hD0 + 64'(i)) begin
                n_fail++;
                $display("FAIL wr_cmd[%0d]: got addr=%h w=%b data=%h required addr=%h w=1 data=%h",
                         i, log_addr[i], log_w[i], log_data[i], beat_addr(a, i),
                         64'hD0 + 64'(i));
            end
        end
        mem_mode = 0; mem_cmd_ready = 1'b1;
        #1;
        n_checks++;
        if (dma_pkt_ready !== 1'b1 || dma_data_ready_out !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_idle: got pkt_ready=%b evict_ready=%b required 1 and 0",
                     dma_pkt_ready, dma_data_ready_out);
        end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] ra, wa;
        logic [FW-1:0] exp_fill[$];
        logic [FW-1:0] wdata[$];
        int            offer_cyc;
        ra = AW'($urandom);
        wa = ra ^ 28'h0008000;
        clear_logs();
        for (int i = 0; i < BLK; i++) exp_fill.push_back(mem_read(beat_addr(ra, i)));
        for (int i = 0; i < BLK; i++) wdata.push_back({$urandom, $urandom});
        for (int i = 0; i < BLK; i++) src_q.push_back(wdata[i]);
        mem_mode = 2; fill_mode = 2; evict_bubbles = 1'b1;
        dma_pkt = {1'b0, ra}; dma_pkt_v = 1'b1;
        for (int i = 0; i < 400 && log_addr.size() < BLK; i++) tick();
        dma_pkt = {1'b1, wa}; dma_pkt_v = 1'b1;
        offer_cyc = cyc;
        tick();
        n_checks++;
        if (pkt_acc_cyc != offer_cyc) begin
            n_fail++;
            $display("FAIL b2b_wr_accept: got accept cycle %0d required %0d", pkt_acc_cyc, offer_cyc);
        end
        for (int i = 0; i < 800 && (log_addr.size() < 2 * BLK || fill_log.size() < BLK); i++)
            tick();
        n_checks++;
        if (log_addr.size() != 2 * BLK || fill_log.size() != BLK) begin
            n_fail++;
            $display("FAIL b2b_counts: got cmds=%0d fills=%0d required %0d and %0d",
                     log_addr.size(), fill_log.size(), 2 * BLK, BLK);
        end
        for (int i = 0; i < 2 * BLK && i < log_addr.size(); i++) begin
            n_checks++;
            if (i < BLK) begin
                if (log_addr[i] !== beat_addr(ra, i) || log_w[i] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_rd[%0d]: got addr=%h w=%b required addr=%h w=0",
                             i, log_addr[i], log_w[i], beat_addr(ra, i));
                end
            end else if (log_addr[i] !== beat_addr(wa, i - BLK) || log_w[i] !== 1'b1 ||
                         log_data[i] !== wdata[i - BLK]) begin
                n_fail++;
                $display("FAIL b2b_wr[%0d]: got addr=%h w=%b data=%h required addr=%h w=1 data=%h",
                         i, log_addr[i], log_w[i], log_data[i], beat_addr(wa, i - BLK),
                         wdata[i - BLK]);
            end
        end
        for (int i = 0; i < BLK && i < fill_log.size(); i++) begin
            n_checks++;
            if (fill_log[i] !== exp_fill[i]) begin
                n_fail++;
                $display("FAIL b2b_fill[%0d]: got %h required %h", i, fill_log[i], exp_fill[i]);
            end
        end
        evict_bubbles = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [AW-1:0] a;
        a = AW'($urandom) | 28'h0100000;
        clear_logs();
        mem_mode = 0; mem_cmd_ready = 1'b1;
        fill_mode = 0; dma_data_ready_in = 1'b1;
        dma_pkt = {1'b0, a}; dma_pkt_v = 1'b1;
        for (int i = 0; i < 200 && fill_log.size() < 3; i++) tick();
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (dma_pkt_ready !== 1'b0 || mem_cmd_v !== 1'b0 || mem_cmd_w !== 1'b0 ||
            mem_cmd_addr !== '0 || mem_cmd_data !== '0 || dma_data_v_out !== 1'b0 ||
            dma_data_out !== '0 || dma_data_ready_out !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got rdy=%b v=%b w=%b addr=%h data=%h fv=%b fd=%h er=%b required all 0",
                     dma_pkt_ready, mem_cmd_v, mem_cmd_w, mem_cmd_addr, mem_cmd_data,
                     dma_data_v_out, dma_data_out, dma_data_ready_out);
        end
        mem_resp_v = 1'b0; mem_resp_data = '0; dma_pkt_v = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        n_checks++;
        if (dma_pkt_ready !== 1'b1 || dma_data_v_out !== 1'b0 || mem_cmd_v !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_release: got rdy=%b fill_v=%b cmd_v=%b required 1 0 0",
                     dma_pkt_ready, dma_data_v_out, mem_cmd_v);
        end
        n_checks++;
        if (dut.credits_q !== 3'(ELS)) begin
            n_fail++;
            $display("FAIL mid_reset_credits: got %0d required %0d", dut.credits_q, ELS);
        end
    endtask

    task automatic test_credit_same_cycle();
        logic [AW-1:0] a;
        logic [FW-1:0] exp_fill[$];
        a = AW'($urandom);
        clear_logs();
        for (int i = 0; i < BLK; i++) exp_fill.push_back(mem_read(beat_addr(a, i)));
        mem_mode = 0; mem_cmd_ready = 1'b1;
        fill_mode = 0; dma_data_ready_in = 1'b0;
        dma_pkt = {1'b0, a}; dma_pkt_v = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        #1;
        n_checks++;
        if (dut.credits_q !== 3'd0 || log_addr.size() != ELS) begin
            n_fail++;
            $display("FAIL cr_drained: got credits=%0d cmds=%0d required 0 and %0d",
                     dut.credits_q, log_addr.size(), ELS);
        end
        mem_cmd_ready = 1'b0; dma_data_ready_in = 1'b1;
        tick();
        #1;
        n_checks++;
        if (dut.credits_q !== 3'd1) begin
            n_fail++;
            $display("FAIL cr_one: got %0d required 1", dut.credits_q);
        end
        mem_cmd_ready = 1'b1; dma_data_ready_in = 1'b1;
        n_checks++;
        if (mem_cmd_v !== 1'b1 || dma_data_v_out !== 1'b1) begin
            n_fail++;
            $display("FAIL cr_both_valid: got cmd_v=%b fill_v=%b required 1 and 1",
                     mem_cmd_v, dma_data_v_out);
        end
        tick();
        #1;
        n_checks++;
        if (dut.credits_q !== 3'd1 || log_addr.size() != ELS + 1 || fill_log.size() != 2) begin
            n_fail++;
            $display("FAIL cr_same_cycle: got credits=%0d cmds=%0d fills=%0d required 1 %0d 2",
                     dut.credits_q, log_addr.size(), fill_log.size(), ELS + 1);
        end
        dma_data_ready_in = 1'b0;
        n_checks++;
        if (mem_cmd_v !== 1'b1) begin
            n_fail++;
            $display("FAIL cr_next_read: got cmd_v=%b required 1", mem_cmd_v);
        end
        tick();
        dma_data_ready_in = 1'b1;
        for (int i = 0; i < 200 && fill_log.size() < BLK; i++) tick();
        n_checks++;
        if (log_addr.size() != BLK || fill_log.size() != BLK) begin
            n_fail++;
            $display("FAIL cr_counts: got cmds=%0d fills=%0d required %0d each",
                     log_addr.size(), fill_log.size(), BLK);
        end
        for (int i = 0; i < BLK && i < fill_log.size() && i < log_addr.size(); i++) begin
            n_checks++;
            if (fill_log[i] !== exp_fill[i] || log_addr[i] !== beat_addr(a, i)) begin
                n_fail++;
                $display("FAIL cr_beat[%0d]: got addr=%h fill=%h required addr=%h fill=%h",
                         i, log_addr[i], fill_log[i], beat_addr(a, i), exp_fill[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_read_basic();
        test_fill_backpressure();
        test_write();
        test_back_to_back();
        test_reset_mid();
        test_credit_same_cycle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
